qam_coherent_demodulator: RTL and testbench

//  Receive-side counterpart of the QAM carrier wave generator. Mixes received passband samples

---
 rtl/qam_coherent_demodulator.sv | 162 ++++++++++++++++
 tb/tb_qam_coherent_demodulator.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_coherent_demodulator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : qam_coherent_demodulator                                          |
// | Brief   : Coherent 16-QAM demodulator: carrier mix, integrate-and-dump per  |
// |           symbol, Gray-coded I/Q slicer with valid/ready output.            |
// |           Optional accumulator saturation via `QAM_DEMOD_SAT_EN.           |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module qam_coherent_demodulator #(
    parameter int                    WAVE_WIDTH      = 16,
    parameter int                    WAVE_WIDTH_F    = 14,
    parameter int                    SAMPLES_PER_SYM = 100,
    parameter int                    CNT_WIDTH       = 10,
    parameter int                    ACC_WIDTH       = 48,
    parameter logic [ACC_WIDTH-1:0]  SLICE_THR       = 48'd8858370048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WAVE_WIDTH-1:0] rx_sample,
    input  logic [WAVE_WIDTH-1:0] carrier_cos,
    input  logic [WAVE_WIDTH-1:0] carrier_sin,
    input  logic                  sample_valid,
    input  logic                  sym_sync,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic [ACC_WIDTH-1:0]  sym_i,
    output logic [ACC_WIDTH-1:0]  sym_q,
    output logic [3:0]            sym_bits,
    output logic                  overrun,
    output logic                  sat_flag
);

    localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(SAMPLES_PER_SYM - 1);

    generate
        if ((2**CNT_WIDTH) <= SAMPLES_PER_SYM || ACC_WIDTH < 2*WAVE_WIDTH ||
            WAVE_WIDTH_F >= WAVE_WIDTH) begin : g_param_check
            $error("qam_coherent_demodulator: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_INTEGRATE = 1'b1
    } state_t;

    state_t                       r_state, w_state_next;
    logic [CNT_WIDTH-1:0]         r_count;
    logic signed [ACC_WIDTH-1:0]  r_acc_i, r_acc_q;
    logic [ACC_WIDTH-1:0]         r_sym_i, r_sym_q;
    logic [3:0]                   r_sym_bits;
    logic                         r_sym_valid, r_overrun, r_sat_flag;

    logic signed [2*WAVE_WIDTH-1:0] w_prod_i, w_prod_q;
    logic signed [ACC_WIDTH-1:0]    w_ext_i, w_ext_q, w_base_i, w_base_q, w_sum_i, w_sum_q;
    logic [CNT_WIDTH-1:0]           w_pos;
    logic                           w_first, w_accept, w_dump, w_clamp;

    // A qualified sync always restarts the symbol, so that sample is position 0.
    assign w_first  = sample_valid & sym_sync;
    assign w_accept = sample_valid & (sym_sync | (r_state == ST_INTEGRATE));
    assign w_pos    = w_first ? '0 : r_count;
    assign w_dump   = w_accept & (w_pos == c_LAST);

    assign w_prod_i = $signed(rx_sample) * $signed(carrier_cos);
    assign w_prod_q = $signed(rx_sample) * $signed(carrier_sin);
    assign w_ext_i  = ACC_WIDTH'(w_prod_i);
    assign w_ext_q  = ACC_WIDTH'(w_prod_q);
    assign w_base_i = w_first ? '0 : r_acc_i;
    assign w_base_q = w_first ? '0 : r_acc_q;

`ifdef QAM_DEMOD_SAT_EN
    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] w_raw_i, w_raw_q;
    logic                      w_ovf_i, w_ovf_q;

    assign w_raw_i = (ACC_WIDTH+1)'(w_base_i) + (ACC_WIDTH+1)'(w_ext_i);
    assign w_raw_q = (ACC_WIDTH+1)'(w_base_q) - (ACC_WIDTH+1)'(w_ext_q);
    assign w_ovf_i = w_raw_i[ACC_WIDTH] ^ w_raw_i[ACC_WIDTH-1];
    assign w_ovf_q = w_raw_q[ACC_WIDTH] ^ w_raw_q[ACC_WIDTH-1];
    assign w_sum_i = w_ovf_i ? (w_raw_i[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX) : w_raw_i[ACC_WIDTH-1:0];
    assign w_sum_q = w_ovf_q ? (w_raw_q[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX) : w_raw_q[ACC_WIDTH-1:0];
    assign w_clamp = w_accept & (w_ovf_i | w_ovf_q);
`else
    assign w_sum_i = w_base_i + w_ext_i;
    assign w_sum_q = w_base_q - w_ext_q;
    assign w_clamp = 1'b0;
`endif

    // Gray pair {neg, inner}: +3->00, +1->01, -1->11, -3->10.
    function automatic logic [1:0] f_slice(input logic signed [ACC_WIDTH-1:0] x);
        logic [ACC_WIDTH-1:0] mag;
        mag = x[ACC_WIDTH-1] ? ACC_WIDTH'(-x) : x;
        return {x[ACC_WIDTH-1], (mag < SLICE_THR)};
    endfunction

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_IDLE && w_first) begin
            w_state_next = ST_INTEGRATE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (w_dump) begin
                    r_count <= '0;
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                end else begin
                    r_count <= w_pos + 1'b1;
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                end
            end
            if (w_clamp) begin
                r_sat_flag <= 1'b1;
            end
        end
    end

    // A dump that meets an unaccepted result is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sym_valid <= 1'b0;
            r_sym_i     <= '0;
            r_sym_q     <= '0;
            r_sym_bits  <= '0;
            r_overrun   <= 1'b0;
        end else if (w_dump) begin
            if (!r_sym_valid || sym_ready) begin
                r_sym_valid <= 1'b1;
                r_sym_i     <= w_sum_i;
                r_sym_q     <= w_sum_q;
                r_sym_bits  <= {f_slice(w_sum_i), f_slice(w_sum_q)};
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_sym_valid && sym_ready) begin
            r_sym_valid <= 1'b0;
        end
    end

    assign sym_valid = r_sym_valid;
    assign sym_i     = r_sym_i;
    assign sym_q     = r_sym_q;
    assign sym_bits  = r_sym_bits;
    assign overrun   = r_overrun;
    assign sat_flag  = r_sat_flag;

endmodule
`default_nettype wire

// File: tb/tb_qam_coherent_demodulator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_qam_coherent_demodulator                                       |
// | Brief   : Self-checking bench: vector table, corner sequences, random model.|
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_qam_coherent_demodulator;

    localparam int          SPS   = 4;
    localparam longint      THR   = 536870912;
    localparam logic [47:0] THR48 = 48'd536870912;
    localparam logic [31:0] THR32 = 32'd536870912;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] rx_sample = '0, carrier_cos = '0, carrier_sin = '0;
    logic        sample_valid = 1'b0, sym_sync = 1'b0, sym_ready = 1'b1;

    logic        sym_valid, overrun, sat_flag;
    logic [47:0] sym_i, sym_q;
    logic [3:0]  sym_bits;

    logic        sym_valid32, overrun32, sat_flag32;
    logic [31:0] sym_i32, sym_q32;
    logic [3:0]  sym_bits32;

    qam_coherent_demodulator #(
        .WAVE_WIDTH(16), .WAVE_WIDTH_F(14), .SAMPLES_PER_SYM(SPS),
        .CNT_WIDTH(3), .ACC_WIDTH(48), .SLICE_THR(THR48)
    ) dut (
        .clk(clk), .reset(reset), .rx_sample(rx_sample), .carrier_cos(carrier_cos),
        .carrier_sin(carrier_sin), .sample_valid(sample_valid), .sym_sync(sym_sync),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_i(sym_i), .sym_q(sym_q),
        .sym_bits(sym_bits), .overrun(overrun), .sat_flag(sat_flag)
    );

    qam_coherent_demodulator #(
        .WAVE_WIDTH(16), .WAVE_WIDTH_F(14), .SAMPLES_PER_SYM(SPS),
        .CNT_WIDTH(3), .ACC_WIDTH(32), .SLICE_THR(THR32)
    ) dut32 (
        .clk(clk), .reset(reset), .rx_sample(rx_sample), .carrier_cos(carrier_cos),
        .carrier_sin(carrier_sin), .sample_valid(sample_valid), .sym_sync(sym_sync),
        .sym_valid(sym_valid32), .sym_ready(sym_ready), .sym_i(sym_i32), .sym_q(sym_q32),
        .sym_bits(sym_bits32), .overrun(overrun32), .sat_flag(sat_flag32)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [15:0] r,
                        input logic [15:0] c, input logic [15:0] sn);
        @(negedge clk);
        sample_valid = v;
        sym_sync     = s;
        rx_sample    = r;
        carrier_cos  = c;
        carrier_sin  = sn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        sample_valid = 1'b0;
        sym_sync     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model: collects samples of the current symbol and sums them when full.
    bit     m_active;
    int     m_rx[$], m_cs[$], m_sn[$];
    bit     m_valid, m_ovr;
    longint m_i, m_q;
    int     m_bits;

    function automatic int gray(input longint x);
        int level;
        if (x >= 0) level = (x < THR) ? 1 : 3;
        else        level = (-x < THR) ? -1 : -3;
        case (level)
            3:       return 0;
            1:       return 1;
            -1:      return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_step();
        bit     nv;
        longint si, sq;
        if (!reset) begin
            m_active = 0;
            m_rx.delete(); m_cs.delete(); m_sn.delete();
            m_valid = 0; m_ovr = 0; m_i = 0; m_q = 0; m_bits = 0;
            return;
        end
        nv = m_valid && !sym_ready;
        if (sample_valid) begin
            if (sym_sync) begin
                m_active = 1;
                m_rx.delete(); m_cs.delete(); m_sn.delete();
            end
            if (m_active) begin
                m_rx.push_back(int'($signed(rx_sample)));
                m_cs.push_back(int'($signed(carrier_cos)));
                m_sn.push_back(int'($signed(carrier_sin)));
            end
            if (m_rx.size() == SPS) begin
                si = 0;
                sq = 0;
                for (int k = 0; k < SPS; k++) begin
                    si += longint'(m_rx[k]) * longint'(m_cs[k]);
                    sq -= longint'(m_rx[k]) * longint'(m_sn[k]);
                end
                m_rx.delete(); m_cs.delete(); m_sn.delete();
                if (m_valid && !sym_ready) begin
                    m_ovr = 1;
                end else begin
                    m_i = si; m_q = sq;
                    m_bits = gray(si) * 4 + gray(sq);
                    nv = 1;
                end
            end
        end
        m_valid = nv;
    endtask

    typedef struct {
        logic [15:0] rx, cs, sn;
        longint      ei, eq;
        logic [3:0]  eb;
    } vec_t;

    vec_t tbl[7];
    int   pulses;
    logic [15:0] r16, c16, s16;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        tbl[0] = '{16'd16384, 16'd16384, 16'd0, 64'sd1073741824, 64'sd0, 4'b0001};
        tbl[1] = '{16'd16384, 16'd0, 16'd16384, 64'sd0, -64'sd1073741824, 4'b0110};
        tbl[2] = '{16'd8192, 16'd8192, 16'(-8192), 64'sd268435456, 64'sd268435456, 4'b0101};
        tbl[3] = '{16'(-8192), 16'd8192, 16'(-16384), -64'sd268435456, -64'sd536870912, 4'b1110};
        tbl[4] = '{16'd16384, 16'd8191, 16'(-8191), 64'sd536805376, 64'sd536805376, 4'b0101};
        tbl[5] = '{16'(-32768), 16'(-32768), 16'd32767, 64'sd4294967296, 64'sd4294836224, 4'b0000};
        tbl[6] = '{16'd16384, 16'd8192, 16'd0, 64'sd536870912, 64'sd0, 4'b0001};

        // Reset state
        do_reset();
        chk("rst_valid", sym_valid, 0);
        chk("rst_i", $signed(sym_i), 0);
        chk("rst_q", $signed(sym_q), 0);
        chk("rst_bits", sym_bits, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sat", sat_flag, 0);

        // Vector table: one full symbol per entry, sync on the first sample
        sym_ready = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step(1'b1, 1'b1, tbl[e].rx, tbl[e].cs, tbl[e].sn);
            for (int k = 1; k < SPS; k++) begin
                if (k == SPS-1) chk("tbl_early_valid", sym_valid, 0);
                step(1'b1, 1'b0, tbl[e].rx, tbl[e].cs, tbl[e].sn);
            end
            chk("tbl_valid", sym_valid, 1);
            chk("tbl_i", $signed(sym_i), tbl[e].ei);
            chk("tbl_q", $signed(sym_q), tbl[e].eq);
            chk("tbl_bits", sym_bits, tbl[e].eb);
        end

        // Backpressure and overrun
        do_reset();
        sym_ready = 1'b0;
        step(1'b1, 1'b1, 16'd16384, 16'd16384, 16'd0);
        for (int k = 1; k < SPS; k++) step(1'b1, 1'b0, 16'd16384, 16'd16384, 16'd0);
        chk("bp_first_valid", sym_valid, 1);
        for (int k = 0; k < SPS; k++) step(1'b1, 1'b0, 16'(-16384), 16'd16384, 16'd0);
        chk("bp_hold_valid", sym_valid, 1);
        chk("bp_hold_i", $signed(sym_i), 1073741824);
        chk("bp_overrun", overrun, 1);
        sym_ready = 1'b1;
        step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        chk("bp_release_valid", sym_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);

        // Resync discards the partial symbol
        do_reset();
        pulses = 0;
        step(1'b1, 1'b1, 16'(-16384), 16'd16384, 16'd0); pulses += int'(sym_valid);
        step(1'b1, 1'b0, 16'(-16384), 16'd16384, 16'd0); pulses += int'(sym_valid);
        step(1'b1, 1'b1, 16'd16384, 16'd16384, 16'd0);   pulses += int'(sym_valid);
        for (int k = 1; k < SPS; k++) begin
            step(1'b1, 1'b0, 16'd16384, 16'd16384, 16'd0);
            pulses += int'(sym_valid);
        end
        chk("resync_valid", sym_valid, 1);
        chk("resync_i", $signed(sym_i), 1073741824);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
            pulses += int'(sym_valid);
        end
        chk("resync_pulses", pulses, 1);

        // Gaps in sample_valid
        do_reset();
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step(k % 2 == 0, k == 0, 16'd16384, 16'd16384, 16'd0);
            pulses += int'(sym_valid);
            if (k == 6) begin
                chk("gap_valid", sym_valid, 1);
                chk("gap_i", $signed(sym_i), 1073741824);
                chk("gap_bits", sym_bits, 4'b0001);
            end
        end
        chk("gap_pulses", pulses, 1);

        // Reset mid-symbol with a held result and overrun pending
        do_reset();
        sym_ready = 1'b0;
        step(1'b1, 1'b1, 16'd16384, 16'd16384, 16'd0);
        for (int k = 1; k < SPS + SPS + 3; k++) step(1'b1, 1'b0, 16'd16384, 16'd16384, 16'd0);
        chk("mid_pre_overrun", overrun, 1);
        do_reset();
        chk("mid_valid", sym_valid, 0);
        chk("mid_i", $signed(sym_i), 0);
        chk("mid_q", $signed(sym_q), 0);
        chk("mid_bits", sym_bits, 0);
        chk("mid_overrun", overrun, 0);
        sym_ready = 1'b1;
        pulses = 0;
        for (int k = 0; k < SPS + 2; k++) begin
            step(k < SPS, 1'b0, 16'd16384, 16'd16384, 16'd0);
            pulses += int'(sym_valid);
        end
        chk("mid_nosync_pulses", pulses, 0);

        // 32-bit accumulator overflow
        do_reset();
        step(1'b1, 1'b1, 16'(-32768), 16'(-32768), 16'd0);
        for (int k = 1; k < SPS; k++) step(1'b1, 1'b0, 16'(-32768), 16'(-32768), 16'd0);
        chk("acc32_valid", sym_valid32, 1);
`ifdef QAM_DEMOD_SAT_EN
        chk("acc32_i", $signed(sym_i32), 2147483647);
        chk("acc32_sat", sat_flag32, 1);
        chk("acc32_bits", sym_bits32, 4'b0001);
`else
        chk("acc32_i", $signed(sym_i32), 0);
        chk("acc32_sat", sat_flag32, 0);
        chk("acc32_bits", sym_bits32, 4'b0101);
`endif

        // Random stimulus against the reference model
        do_reset();
        model_step();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            chk("rnd_valid", sym_valid, longint'(m_valid));
            chk("rnd_i", $signed(sym_i), m_i);
            chk("rnd_q", $signed(sym_q), m_q);
            chk("rnd_bits", sym_bits, m_bits);
            chk("rnd_overrun", overrun, longint'(m_ovr));
            chk("rnd_sat", sat_flag, 0);
            r16 = 16'($urandom);
            c16 = 16'($urandom);
            s16 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                r16 = 16'($signed(r16) >>> 4);
                c16 = 16'($signed(c16) >>> 2);
                s16 = 16'($signed(s16) >>> 2);
            end
            rx_sample    = r16;
            carrier_cos  = c16;
            carrier_sin  = s16;
            reset        = ($urandom_range(0, 299) != 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            sym_sync     = ($urandom_range(0, 15) == 0);
            sym_ready    = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
